// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP test-pattern transmitter: FSM state
// encoding, test-pattern select codes and a small elaboration helper.
package dvp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBP    = 3'd2,
    ACTIVE = 3'd3,
    HBLANK = 3'd4,
    VFP    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PAT_X   = 2'd0,  // horizontal ramp
    PAT_Y   = 2'd1,  // vertical ramp
    PAT_XOR = 2'd2,  // x ^ y checkerboard-like pattern
    PAT_RED = 2'd3   // solid RGB565 red
  } pat_t;

  localparam logic [15:0] RED_565 = 16'hF800;

  // Larger of two integers, used to size the shared timing counter.
  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational pixel generator: selects the RGB565 test pattern for the
// current (x, y) position. Optional macro DVP_TX_FRAME_TAG_EN replaces
// pixel (0,0) of every frame with the completed-frame count.
module dvp_pattern_gen
  import dvp_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  pat_t        sel,
  input  logic [15:0] frame_cnt,
  output logic [15:0] pixel
);

  logic [15:0] pattern;

  // Pattern value for the current position.
  always_comb begin
    pattern = 16'h0000;
    unique case (sel)
      PAT_X:   pattern = x;
      PAT_Y:   pattern = y;
      PAT_XOR: pattern = x ^ y;
      PAT_RED: pattern = RED_565;
    endcase
  end

`ifdef DVP_TX_FRAME_TAG_EN
  // First pixel of the frame carries the frame number.
  assign pixel = ((x == 16'd0) && (y == 16'd0)) ? frame_cnt : pattern;
`else
  logic unused_frame_cnt;
  assign unused_frame_cnt = ^frame_cnt;
  assign pixel = pattern;
`endif

endmodule

// File: rtl/dvp_pattern_tx.sv
// DVP (camera-style) test-pattern transmitter. Generates vsync/href
// framing and RGB565 pixel bytes (high byte first) from a six-state FSM.
// Optional macro: DVP_TX_FRAME_TAG_EN (frame number in pixel (0,0)).
module dvp_pattern_tx
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE  = 16,
  parameter int V_ACTIVE  = 8,
  parameter int H_BLANK   = 8,
  parameter int VSYNC_CYC = 32,
  parameter int VBP_CYC   = 16,
  parameter int VFP_CYC   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        cmos_vsync,
  output logic        cmos_href,
  output logic [7:0]  cmos_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  // One counter times every phase; in ACTIVE it is the byte index.
  localparam int CNT_MAX = max_of(max_of(max_of(2 * H_ACTIVE, V_ACTIVE),
                                         max_of(H_BLANK, VSYNC_CYC)),
                                  max_of(VBP_CYC, VFP_CYC));
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] VSYNC_LAST = CNT_W'(VSYNC_CYC - 1);
  localparam logic [CNT_W-1:0] VBP_LAST   = CNT_W'(VBP_CYC - 1);
  localparam logic [CNT_W-1:0] ACT_LAST   = CNT_W'(2 * H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HB_LAST    = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] VFP_LAST   = CNT_W'(VFP_CYC - 1);
  localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(V_ACTIVE - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] y, y_nxt;
  pat_t             sel_q, sel_nxt;
  logic             last_line;
  logic [15:0]      pixel;

  assign last_line = (y == Y_LAST);

  // State, counters and latched pattern select.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      y         <= '0;
      sel_q     <= PAT_X;
      frame_cnt <= 16'h0000;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      y     <= y_nxt;
      sel_q <= sel_nxt;
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Next-state and counter update; pattern select latched at frame start.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    y_nxt     = y;
    sel_nxt   = sel_q;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (enable) begin
          state_nxt = VSYNC;
          sel_nxt   = pat_t'(pattern_sel);
        end
      end
      VSYNC: begin
        if (cnt == VSYNC_LAST) begin
          state_nxt = VBP;
          cnt_nxt   = '0;
        end
      end
      VBP: begin
        if (cnt == VBP_LAST) begin
          state_nxt = ACTIVE;
          cnt_nxt   = '0;
          y_nxt     = '0;
        end
      end
      ACTIVE: begin
        if (cnt == ACT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = last_line ? VFP : HBLANK;
        end
      end
      HBLANK: begin
        if (cnt == HB_LAST) begin
          state_nxt = ACTIVE;
          cnt_nxt   = '0;
          y_nxt     = y + CNT_W'(1);
        end
      end
      VFP: begin
        if (cnt == VFP_LAST) begin
          cnt_nxt = '0;
          y_nxt   = '0;
          if (enable) begin
            state_nxt = VSYNC;
            sel_nxt   = pat_t'(pattern_sel);
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        y_nxt     = '0;
      end
    endcase
  end

  dvp_pattern_gen u_pattern_gen (
    .x         (16'(cnt >> 1)),
    .y         (16'(y)),
    .sel       (sel_q),
    .frame_cnt (frame_cnt),
    .pixel     (pixel)
  );

  // Moore outputs decoded from registered state only.
  assign cmos_vsync = (state == VSYNC);
  assign cmos_href  = (state == ACTIVE);
  assign cmos_data  = !cmos_href ? 8'h00 : (cnt[0] ? pixel[7:0] : pixel[15:8]);
  assign frame_done = (state == ACTIVE) && (cnt == ACT_LAST) && last_line;

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Self-checking bench for dvp_pattern_tx: frame-timeline reference model
// compared every cycle, plus literal checks on key frame features.
module tb_dvp_pattern_tx;

  localparam int H      = 16;
  localparam int V      = 8;
  localparam int HB     = 8;
  localparam int VS     = 32;
  localparam int VBPC   = 16;
  localparam int VFPC   = 16;
  localparam int LINE   = 2 * H + HB;
  localparam int ACT0   = VS + VBPC;
  localparam int ACTLEN = V * LINE - HB;
  localparam int FLEN   = ACT0 + ACTLEN + VFPC;
  localparam int BUDGET = 3 * FLEN;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [1:0]  pattern_sel = 2'd0;
  logic        cmos_vsync, cmos_href, frame_done;
  logic [7:0]  cmos_data;
  logic [15:0] frame_cnt;

  int tests = 0;
  int fails = 0;

  dvp_pattern_tx #(
    .H_ACTIVE (H), .V_ACTIVE (V), .H_BLANK (HB),
    .VSYNC_CYC (VS), .VBP_CYC (VBPC), .VFP_CYC (VFPC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .cmos_vsync  (cmos_vsync),
    .cmos_href   (cmos_href),
    .cmos_data   (cmos_data),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: position within a frame timeline
  typedef struct packed {
    logic       vs;
    logic       hr;
    logic       done;
    logic [7:0] data;
  } exp_t;

  bit          m_run = 0;
  int          m_t   = 0;
  int          m_sel = 0;
  logic [15:0] m_cnt = 16'h0;

  function automatic exp_t model_out(input bit run, input int t, input int sel,
                                     input logic [15:0] fcnt);
    exp_t        e;
    int          u, line, p, x;
    logic [15:0] pix;
    e = '0;
    if (run) begin
      e.vs = (t < VS);
      if (t >= ACT0 && t < ACT0 + ACTLEN) begin
        u    = t - ACT0;
        line = u / LINE;
        p    = u % LINE;
        if (p < 2 * H) begin
          x = p / 2;
          case (sel)
            0:       pix = 16'(x);
            1:       pix = 16'(line);
            2:       pix = 16'(x ^ line);
            default: pix = 16'hF800;
          endcase
`ifdef DVP_TX_FRAME_TAG_EN
          if (x == 0 && line == 0) pix = fcnt;
`endif
          e.hr   = 1'b1;
          e.data = (p % 2 == 0) ? pix[15:8] : pix[7:0];
          e.done = (line == V - 1) && (p == 2 * H - 1);
        end
      end
    end
    return e;
  endfunction

  // Advance the model one clock, sampling the same inputs the DUT sees.
  always @(posedge clk or posedge rst) begin
    exp_t e;
    if (rst) begin
      m_run = 0; m_t = 0; m_sel = 0; m_cnt = 16'h0;
    end else begin
      e = model_out(m_run, m_t, m_sel, m_cnt);
      if (e.done) m_cnt = m_cnt + 16'd1;
      if (!m_run) begin
        if (enable) begin m_run = 1; m_t = 0; m_sel = int'(pattern_sel); end
      end else if (m_t == FLEN - 1) begin
        if (enable) begin m_t = 0; m_sel = int'(pattern_sel); end
        else m_run = 0;
      end else begin
        m_t++;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      e = model_out(m_run, m_t, m_sel, m_cnt);
      check("vsync",      cmos_vsync, e.vs);
      check("href",       cmos_href,  e.hr);
      check("data",       cmos_data,  e.data);
      check("frame_done", frame_done, e.done);
      check("frame_cnt",  frame_cnt,  m_cnt);
    end
  end

  // ---------------- stimulus helpers (all return on a falling edge)
  function automatic logic sig(input int which);
    case (which)
      0:       return cmos_vsync;
      1:       return cmos_href;
      default: return frame_done;
    endcase
  endfunction

  task automatic wait_rise(input int which, input string name);
    int   n;
    logic prev;
    n    = 0;
    prev = sig(which);
    @(negedge clk);
    while (!(sig(which) && !prev) && n < BUDGET) begin
      prev = sig(which);
      n++;
      @(negedge clk);
    end
    check({name, "_in_time"}, (n < BUDGET), 1);
  endtask

  task automatic count_until(input int which, input logic level, input int limit,
                             output int n);
    n = 0;
    while (sig(which) !== level && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_vsync", cmos_vsync, 0);
    check("rst_href",  cmos_href,  0);
    check("rst_data",  cmos_data,  0);
    check("rst_done",  frame_done, 0);
    check("rst_fcnt",  frame_cnt,  0);
    rst = 1'b0;

    // Frame 0, ramp: vsync width, back porch, line 0 bytes.
    wait_rise(0, "vsync0");
    count_until(0, 1'b0, 100, n);
    check("vsync_len", n, 32);
    count_until(1, 1'b1, 100, n);
    check("vbp_len", n, 16);
    for (int i = 0; i < 2 * H; i++) begin
      check("line0_byte", cmos_data, (i % 2 == 1) ? (i / 2) : 0);
      @(negedge clk);
    end
    pattern_sel = 2'd1;
    wait_rise(2, "done0");
    @(negedge clk);
    check("fcnt_after_frame0", frame_cnt, 1);

    // Frame 1, vertical ramp: line shapes, line 5 bytes; switch to red mid-frame.
    wait_rise(0, "vsync1");
    for (int l = 0; l < V; l++) begin
      count_until(1, 1'b1, 100, n);
      if (l > 0) check("hblank_len", n, 8);
      n = 0;
      while (cmos_href && n < 100) begin
        if (l == 5) check("line5_byte", cmos_data, (n % 2 == 1) ? 5 : 0);
        if (l == 3 && n == 0) pattern_sel = 2'd3;
        n++;
        @(negedge clk);
      end
      check("href_len", n, 32);
    end

    // Frame 2 must be solid red.
    wait_rise(0, "vsync2");
    count_until(1, 1'b1, 100, n);
    for (int i = 0; i < 2 * H; i++) begin
      if (i >= 2) check("red_byte", cmos_data, (i % 2 == 1) ? 8'h00 : 8'hF8);
      @(negedge clk);
    end

    // Randomized run: pattern changes and occasional enable toggles.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) pattern_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) enable = ~enable;
    end

    // Drop enable at line 3: frame completes, then stays idle.
    enable = 1'b1;
    wait_rise(0, "vsync_en");
    repeat (4) wait_rise(1, "href_en");
    enable = 1'b0;
    wait_rise(2, "done_en");
    count_until(0, 1'b1, 500, n);
    check("no_second_vsync", n, 500);
    check("idle_href", cmos_href, 0);
    check("idle_data", cmos_data, 0);

    // Reset during line 2 aborts at once; restart with full vsync.
    enable = 1'b1;
    wait_rise(0, "vsync_rst");
    repeat (3) wait_rise(1, "href_rst");
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_vsync", cmos_vsync, 0);
    check("async_href",  cmos_href,  0);
    check("async_data",  cmos_data,  0);
    check("async_fcnt",  frame_cnt,  0);
    @(negedge clk);
    #2 rst = 1'b0;
    wait_rise(0, "vsync_after_rst");
    count_until(0, 1'b0, 100, n);
    check("vsync_len_after_rst", n, 32);
    check("fcnt_after_rst", frame_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dvp_pattern_tx.md
DVP_PATTERN_TX -- requirements
Module: dvp_pattern_tx

Interface
REQ-001 Parameter H_ACTIVE, default 16, meaning active pixels per line (2 bytes each).
REQ-002 Parameter V_ACTIVE, default 8, meaning active lines per frame.
REQ-003 Parameter H_BLANK, default 8, meaning href-low clocks between lines.
REQ-004 Parameter VSYNC_CYC, default 32, meaning vsync-high clocks.
REQ-005 Parameter VBP_CYC, default 16, meaning clocks from vsync fall to first href; VFP_CYC, default 16, clocks from last href fall to next vsync rise.
REQ-006 clk  input  1  sole clock; all outputs change only on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 enable  input  1  run request; sampled only at frame boundaries.
REQ-009 pattern_sel  input  2  test pattern select.
REQ-010 cmos_vsync  output  1  frame sync, active-high.
REQ-011 cmos_href  output  1  line valid, active-high.
REQ-012 cmos_data  output  8  pixel byte, RGB565, high byte first.
REQ-013 frame_done  output  1  one-clock pulse on the last byte of each frame.
REQ-014 frame_cnt  output  16  completed-frame count, wraps 0xFFFF->0.

Function
REQ-015 FSM states: IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP.
REQ-016 IDLE->VSYNC when enable=1; otherwise stay IDLE with all outputs 0.
REQ-017 VSYNC lasts exactly VSYNC_CYC clocks with cmos_vsync=1, then VBP.
REQ-018 VBP lasts VBP_CYC clocks, then ACTIVE with x=0, y=0.
REQ-019 ACTIVE lasts 2*H_ACTIVE clocks with cmos_href=1; even byte = pixel[15:8], odd byte = pixel[7:0].
REQ-020 After ACTIVE: if y<V_ACTIVE-1 go HBLANK (H_BLANK clocks), y++, back to ACTIVE; else go VFP.
REQ-021 VFP lasts VFP_CYC clocks; at its end go VSYNC if enable=1, else IDLE.
REQ-022 enable deassert mid-frame has no effect until the current frame completes VFP.
REQ-023 pattern_sel latched on IDLE->VSYNC and VFP->VSYNC transitions only; constant within a frame.
REQ-024 Pixel: sel 0 = x[15:0]; sel 1 = y[15:0]; sel 2 = x^y (16-bit); sel 3 = 16'hF800.
REQ-025 cmos_data=0 whenever cmos_href=0.
REQ-026 frame_done asserted in the same clock as the final byte of line V_ACTIVE-1; frame_cnt increments on the following edge.
REQ-027 Counter widths sized by $clog2 of the largest parameter; no overflow for any legal parameter set (all parameters >=1).

Reset
REQ-028 rst=1 forces state IDLE, x=y=0, all timing counters 0, cmos_vsync=cmos_href=0, cmos_data=0, frame_done=0, frame_cnt=0, latched pattern 0.
REQ-029 rst asserted mid-frame aborts immediately; after release the first frame restarts from VSYNC with full VSYNC_CYC.

Configuration
REQ-030 Macro DVP_TX_FRAME_TAG_EN: when defined, pixel (x=0,y=0) of each frame carries frame_cnt instead of the pattern value; when undefined, every pixel follows REQ-024.

Structure
REQ-031 State encoding enum and pattern_sel codes reside in shared package dvp_pkg.
REQ-032 Pixel generation (pattern select + tag mux) is sub-module dvp_pattern_gen, combinational on x, y, latched sel, frame_cnt; FSM and counters stay in top.

Verification
REQ-033 Defaults, enable=1 from reset release, sel=0 -> vsync high 32 clocks, href rises 16 clocks after vsync fall, line 0 bytes 00,00,00,01,...,00,0F.
REQ-034 sel=1 -> 8 href pulses of 32 clocks separated by 8 low clocks; line 5 bytes all alternate 00,05; frame_done pulses once; frame_cnt=1.
REQ-035 enable dropped at line 3 of frame 0 -> frame completes, VFP 16 clocks, then IDLE with all outputs 0; no second vsync.
REQ-036 pattern_sel changed 0->3 mid-frame -> current frame stays ramp; next frame bytes F8,00 repeated.
REQ-037 rst pulsed during ACTIVE line 2 -> outputs 0 asynchronously; after release full 32-clock vsync, frame_cnt=0.
REQ-038 DVP_TX_FRAME_TAG_EN defined, sel=3, three frames -> first two bytes per frame 00,00 / 00,01 / 00,02; remaining bytes F8,00.
